auto_contrast_ctrl: RTL

- Per-frame controller that generates the 9-bit contrast gain (adjust_val, 0..511 = 0..2.0x, Q1.8) for the linear contrast datapath.
- Measures the peak channel value of each frame and computes gain = 255*256/peak with a sequential restoring divider.
- Applies the new gain only inside vertical blanking, so the gain never changes mid-frame.
- Sits beside the contrast stage on the same pixel stream; a manual override path is provided.

---
 rtl/auto_contrast_pkg.sv | 41 ++++
 rtl/seq_divider_u16.sv | 74 +++++++
 rtl/auto_contrast_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/auto_contrast_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : auto_contrast_pkg
//  Description : Shared types, constants and helpers for the auto-contrast
//                gain controller (FSM states, widths, divider constants).
//  Revision    : 1.0 - initial release
// ============================================================================
package auto_contrast_pkg;

   localparam int          GAIN_W   = 9;
   localparam int          CH_W     = 8;
   localparam logic [15:0] DIV_NUM  = 16'd65280;   // 255 * 256
   localparam int          DIV_ITER = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIV   = 2'd1,
      ST_CLAMP = 2'd2,
      ST_APPLY = 2'd3
   } state_t;

   // Largest of the three colour channels of a packed {R,G,B} pixel.
   function automatic logic [CH_W-1:0] max3(input logic [3*CH_W-1:0] px);
      logic [CH_W-1:0] m;
      m = px[3*CH_W-1:2*CH_W];
      if (px[2*CH_W-1:CH_W] > m) m = px[2*CH_W-1:CH_W];
      if (px[CH_W-1:0] > m)      m = px[CH_W-1:0];
      return m;
   endfunction

   // Saturate a 16-bit quotient into the [lo, hi] gain window.
   function automatic logic [GAIN_W-1:0] clamp_gain(input logic [15:0]       q,
                                                    input logic [GAIN_W-1:0] lo,
                                                    input logic [GAIN_W-1:0] hi);
      if (q > {7'd0, hi})      return hi;
      else if (q < {7'd0, lo}) return lo;
      else                     return q[GAIN_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_u16.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_u16
//  Description : Sequential restoring divider, 16-bit numerator by 8-bit
//                denominator, one quotient bit per cycle. A zero denominator
//                returns 16'hFFFF after the same number of cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_u16
   import auto_contrast_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] num,
   input  logic [7:0]  den,
   output logic [15:0] quotient,
   output logic        done,      // final iteration executes on the coming edge
   output logic        busy,
   output logic        den_zero
);

   localparam logic [4:0] c_iter_ld = 5'(DIV_ITER);

   logic [16:0] rem;
   logic [15:0] quo;
   logic [7:0]  den_r;
   logic [4:0]  cnt;
   logic        zero_r;

   logic [17:0] w_shift;
   logic [17:0] w_diff;

   // Shift the next numerator bit into the partial remainder and trial-subtract.
   always_comb begin
      w_shift = {rem, quo[15]};
      w_diff  = w_shift - {10'd0, den_r};
   end

   // Load on start, then one restoring step per cycle until the count expires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem    <= '0;
         quo    <= '0;
         den_r  <= '0;
         cnt    <= '0;
         zero_r <= 1'b0;
      end else if (start) begin
         rem    <= '0;
         quo    <= num;
         den_r  <= den;
         cnt    <= c_iter_ld;
         zero_r <= (den == 8'd0);
      end else if (cnt != 5'd0) begin
         cnt <= cnt - 5'd1;
         if (zero_r) begin
            quo <= 16'hFFFF;
         end else if (!w_diff[17]) begin
            rem <= w_diff[16:0];
            quo <= {quo[14:0], 1'b1};
         end else begin
            rem <= w_shift[16:0];
            quo <= {quo[14:0], 1'b0};
         end
      end
   end

   assign quotient = quo;
   assign done     = (cnt == 5'd1);
   assign busy     = (cnt != 5'd0);
   assign den_zero = zero_r;

endmodule
`default_nettype wire

// File: rtl/auto_contrast_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : auto_contrast_ctrl
//  Description : Per-frame contrast gain controller. Tracks the frame peak
//                channel value, divides 255*256 by it, clamps, and writes the
//                Q1.8 gain only during vertical blanking (deferred to the next
//                blanking edge if computed mid-frame). Manual override path.
//  Options     : AUTO_CONTRAST_IIR_EN - first-order smoothing (1/4 step) of
//                the written gain instead of a direct write.
//  Revision    : 1.0 - initial release
// ============================================================================
module auto_contrast_ctrl
   import auto_contrast_pkg::*;
#(
   parameter logic [8:0] MIN_GAIN   = 9'd256,
   parameter logic [8:0] MAX_GAIN   = 9'd511,
   parameter logic [8:0] RESET_GAIN = 9'd256
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        vs_in,
   input  logic        valid_i,
   input  logic [23:0] img_data_i,
   input  logic        manual_en,
   input  logic [8:0]  manual_val,
   output logic [8:0]  adjust_val,
   output logic        gain_update,
   output logic        busy
);

   state_t      state, state_nxt;
   logic        vs_d;
   logic [7:0]  peak;
   logic [8:0]  g;
   logic [8:0]  pending_val;
   logic        pending_flag;

   logic        w_vs_rise;
   logic        w_start;
   logic [15:0] w_div_q;
   logic        w_div_done;
   logic        w_div_busy;
   logic        w_div_zero;
   logic [15:0] w_quot;
   logic [8:0]  w_sel;
   logic [8:0]  w_new;

   assign w_vs_rise = vs_in & ~vs_d;
   assign w_start   = w_vs_rise && (state == ST_IDLE);

   // The divider captures the running peak on start; it acts as the latched copy.
   seq_divider_u16 u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (w_start),
      .num      (DIV_NUM),
      .den      (peak),
      .quotient (w_div_q),
      .done     (w_div_done),
      .busy     (w_div_busy),
      .den_zero (w_div_zero)
   );

   assign w_quot = w_div_zero ? 16'hFFFF : w_div_q;
   assign busy   = (state != ST_IDLE);

   // Blanking edge detector and per-frame peak tracker.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_d <= 1'b0;
         peak <= '0;
      end else begin
         vs_d <= vs_in;
         if (w_vs_rise)
            peak <= '0;
         else if (valid_i && !vs_in && (max3(img_data_i) > peak))
            peak <= max3(img_data_i);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // FSM next state; edges arriving while busy are not restarted.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (w_start) state_nxt = ST_DIV;
         ST_DIV:   if (w_div_done || !w_div_busy) state_nxt = ST_CLAMP;
         ST_CLAMP: state_nxt = ST_APPLY;
         ST_APPLY: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Saturated gain, registered in CLAMP so APPLY sees a stable value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  g <= RESET_GAIN;
      else if (state == ST_CLAMP) g <= clamp_gain(w_quot, MIN_GAIN, MAX_GAIN);
   end

   assign w_sel = manual_en ? manual_val : g;

`ifdef AUTO_CONTRAST_IIR_EN
   logic signed [10:0] w_delta;
   logic signed [10:0] w_step;
   logic signed [10:0] w_sum;

   // Move a quarter of the way to the target; one spare bit keeps the sum exact.
   always_comb begin
      w_delta = $signed({2'b00, w_sel}) - $signed({2'b00, adjust_val});
      w_step  = w_delta >>> 2;
      w_sum   = $signed({2'b00, adjust_val}) + w_step;
      w_new   = w_sum[8:0];
      if (manual_en) begin
         if (w_sum < 11'sd0)        w_new = 9'd0;
         else if (w_sum > 11'sd511) w_new = 9'd511;
      end else begin
         if (w_sum < $signed({2'b00, MIN_GAIN}))      w_new = MIN_GAIN;
         else if (w_sum > $signed({2'b00, MAX_GAIN})) w_new = MAX_GAIN;
      end
   end
`else
   assign w_new = w_sel;
`endif

   // Gain output: commit deferred values on the blanking edge, write in APPLY.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adjust_val   <= RESET_GAIN;
         gain_update  <= 1'b0;
         pending_val  <= '0;
         pending_flag <= 1'b0;
      end else begin
         gain_update <= 1'b0;
         if (w_vs_rise && pending_flag) begin
            adjust_val   <= pending_val;
            gain_update  <= 1'b1;
            pending_flag <= 1'b0;
         end
         if (state == ST_APPLY) begin
            if (vs_in) begin
               adjust_val   <= w_new;
               gain_update  <= 1'b1;
               pending_flag <= 1'b0;
            end else begin
               pending_val  <= w_new;
               pending_flag <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
